// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit add/subtract built around one 4-bit ripple adder.
// Optional accumulate operand source: define NIBBLE_SERIAL_ACCUM_EN.

module nibble_serial_addsub_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
`ifdef NIBBLE_SERIAL_ACCUM_EN
    input  logic             use_acc,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] a_load;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             sub_q;
    logic             co_q;
    logic             ov_q;
    logic [3:0]       b_eff;
    logic [3:0]       sum;
    logic             co;
    logic             last;
    logic             accept;

    // Adder inputs always come from held registers, so they never float.
    assign b_eff = b_sh[3:0] ^ {4{sub_q}};

    nibble_serial_addsub_add4 u_add4 (
        .a  (a_sh[3:0]),
        .b  (b_eff),
        .ci (carry_q),
        .s  (sum),
        .co (co)
    );

    if (NIBBLES == 1) begin : g_one
        assign res_shift = sum;
    end else begin : g_many
        assign res_shift = {sum, res_q[WIDTH-1:4]};
    end

`ifdef NIBBLE_SERIAL_ACCUM_EN
    assign a_load = use_acc ? res_q : a;
`else
    assign a_load = a;
`endif

    assign last   = (cnt_q == CW'(NIBBLES - 1));
    assign accept = (state_q == IDLE) && start_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid)  state_d = RUN;
            RUN:     if (last)         state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_load;
            b_sh    <= b;
            sub_q   <= op_sub;
            carry_q <= op_sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_shift;
            a_sh    <= a_sh >> 4;
            b_sh    <= b_sh >> 4;
            carry_q <= co;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                co_q <= co;
                // carry into the MSB xor carry out of it
                ov_q <= a_sh[3] ^ b_eff[3] ^ sum[3] ^ co;
            end
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = res_q;
    assign carry_out    = co_q;
    assign overflow     = ov_q;
endmodule
